// File: rtl/dmux_sync_arb_if.sv
// dmux_sync_arb_if: requester handshake, held channel and ack bundle for dmux_sync_arb
`timescale 1ns/1ps
interface dmux_sync_arb_if #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic src_toggle;
  logic [WIDTH-1:0] src_data;
  logic [IDW-1:0] src_id;
  logic ack_toggle;
  logic busy;
  logic timeout_err;
  modport master (
    output req_valid, req_data, ack_toggle,
    input req_ready, src_toggle, src_data, src_id, busy, timeout_err
  );
  modport slave (
    input req_valid, req_data, ack_toggle,
    output req_ready, src_toggle, src_data, src_id, busy, timeout_err
  );
endinterface

// File: rtl/dmux_sync_arb.sv
// dmux_sync_arb: round-robin source-side arbiter feeding one dmux_sync channel; DMUX_SYNC_ARB_TIMEOUT_EN adds an ack timeout
`timescale 1ns/1ps
module dmux_sync_arb #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int TIMEOUT = 64
) (
  input logic src_clk,
  input logic src_rst_n,
  dmux_sync_arb_if.slave bus
);
  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;
  typedef enum logic {IDLE, WAIT_ACK} state_t;
  state_t state, state_nxt;
  logic [IDW-1:0] ptr, g;
  logic any, grant, tmo, ack_s, ack_evt, ack_prev;
  logic [DEPTH-1:0] ack_sync;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return IDW'(s >= NREQ ? s - NREQ : s);
  endfunction

  // round-robin search: nearest valid requester at or above ptr, wrapping at NREQ
  always_comb begin
    g = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      g = bus.req_valid[wrap_add(ptr, k)] ? wrap_add(ptr, k) : g;
      any = any | bus.req_valid[wrap_add(ptr, k)];
    end
  end

  assign ack_s = ack_sync[DEPTH-1];
  assign ack_evt = ack_s ^ ack_prev;
  assign grant = (state == IDLE) && any;
  assign bus.req_ready = (grant && src_rst_n) ? NREQ'(1) << g : '0;
  assign bus.busy = (state == WAIT_ACK);
  assign bus.timeout_err = tmo;

  // next state: a grant leaves IDLE, an ack (or timeout) returns to it
  always_comb begin
    state_nxt = state;
    state_nxt = grant ? WAIT_ACK : (state == WAIT_ACK && (ack_evt || tmo)) ? IDLE : state;
  end

  // FSM state register
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  // ack toggle resynchroniser plus previous value for edge detection
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      ack_sync <= '0;
      ack_prev <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[DEPTH-2:0], bus.ack_toggle};
      ack_prev <= ack_s;
    end
  end

  // channel registers: capture granted word and id, flip toggle, advance pointer past the winner
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      bus.src_data <= '0;
      bus.src_id <= '0;
      bus.src_toggle <= 1'b0;
      ptr <= '0;
    end else if (grant) begin
      bus.src_data <= bus.req_data[g*WIDTH +: WIDTH];
      bus.src_id <= g;
      bus.src_toggle <= ~bus.src_toggle;
      ptr <= wrap_add(g, 1);
    end
  end

`ifdef DMUX_SYNC_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt;

  // wait counter: cleared on grant, counts cycles spent in WAIT_ACK
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) cnt <= '0;
    else cnt <= grant ? '0 : (state == WAIT_ACK) ? cnt + 1'b1 : cnt;
  end

  assign tmo = (state == WAIT_ACK) && !ack_evt && (cnt == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif
endmodule

// File: tb/tb_dmux_sync_arb.sv
// tb_dmux_sync_arb: directed and randomised bench checking dmux_sync_arb against a transaction-level model
`timescale 1ns/1ps
module tb_dmux_sync_arb;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int TIMEOUT = 8;
`ifdef DMUX_SYNC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  dmux_sync_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  dmux_sync_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .src_clk(clk),
    .src_rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction-level model: busy flag, pointer, last sent word, ack history seen DEPTH cycles late
  int m_ptr, m_id, m_wait;
  bit m_busy, m_tog;
  logic [WIDTH-1:0] m_data;
  bit aq[$];

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ] === 1'b1) return (p + k) % NREQ;
    return -1;
  endfunction

  initial repeat (DEPTH + 1) aq.push_back(1'b0);

  always @(posedge clk or negedge rst_n) begin : model
    int g;
    bit evt;
    if (!rst_n) begin
      m_ptr = 0; m_id = 0; m_wait = 0; m_busy = 0; m_tog = 0; m_data = '0;
      aq.delete();
      repeat (DEPTH + 1) aq.push_back(1'b0);
    end else begin
      evt = aq[1] != aq[0];
      if (!m_busy) begin
        g = rr_pick(bus.req_valid, m_ptr);
        if (g >= 0) begin
          m_busy = 1; m_wait = 0; m_id = g; m_tog = !m_tog;
          m_data = bus.req_data[g*WIDTH +: WIDTH];
          m_ptr = (g + 1) % NREQ;
        end
      end else if (evt || (TO_EN && m_wait == TIMEOUT - 1)) m_busy = 0;
      else m_wait++;
      aq.push_back(bus.ack_toggle === 1'b1);
      void'(aq.pop_front());
    end
  end

  always @(negedge clk) begin : cmp
    int g;
    if (chk_en) begin
      g = rr_pick(bus.req_valid, m_ptr);
      chk("req_ready", bus.req_ready, (rst_n && !m_busy && g >= 0) ? 32'd1 << g : 32'd0);
      chk("src_toggle", bus.src_toggle, m_tog);
      chk("src_data", bus.src_data, m_data);
      chk("src_id", bus.src_id, m_id);
      chk("busy", bus.busy, m_busy);
      chk("timeout_err", bus.timeout_err, TO_EN && m_busy && m_wait == TIMEOUT - 1 && aq[1] == aq[0]);
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic neg(); @(negedge clk); endtask

  task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] d);
    bus.req_valid[i] = v;
    bus.req_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 0; bus.ack_toggle = 0; bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
  endtask

  task automatic wait_busy(input bit lvl);
    for (int n = 0; n < 40; n++) begin
      neg();
      if (bus.busy === lvl) return;
      tick();
    end
    chk("wait_busy", bus.busy, lvl);
  endtask

  task automatic flip_ack();
    tick();
    bus.ack_toggle = ~bus.ack_toggle;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] acc;
    bit acked;
    int pend;
    bus.req_valid = '0; bus.req_data = '0; bus.ack_toggle = 0; rst_n = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    chk_en = 1;
    neg();
    chk("rst_toggle", bus.src_toggle, 0);
    chk("rst_data", bus.src_data, 0);
    chk("rst_id", bus.src_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.req_ready, 0);
    // single transfer
    tick(); set_req(2, 1, 8'hA5);
    neg(); chk("single_ready", bus.req_ready, 4'b0100);
    tick(); bus.req_valid = '0;
    neg();
    chk("single_toggle", bus.src_toggle, 1);
    chk("single_data", bus.src_data, 8'hA5);
    chk("single_id", bus.src_id, 2);
    chk("single_busy", bus.busy, 1);
    chk("single_ready_off", bus.req_ready, 0);
    flip_ack();
    for (int e = 1; e <= 3; e++) begin
      tick(); neg();
      chk("ack_latency_busy", bus.busy, e < 3);
    end
    // round-robin fairness
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, WIDTH'(16 + i));
    for (int k = 0; k < 5; k++) begin
      wait_busy(1);
      chk("rr_id", bus.src_id, k % 4);
      chk("rr_data", bus.src_data, 16 + k % 4);
      chk("rr_toggle", bus.src_toggle, (k + 1) % 2);
      if (k == 4) bus.req_valid = '0;
      flip_ack();
      wait_busy(0);
    end
    // hold stability while waiting for ack
    set_req(1, 1, 8'h5C);
    wait_busy(1);
    chk("hold_id0", bus.src_id, 1);
    chk("hold_data0", bus.src_data, 8'h5C);
    tick(); set_req(1, 1, 8'hFF);
    repeat (2) begin
      neg();
      chk("hold_data", bus.src_data, 8'h5C);
      chk("hold_id", bus.src_id, 1);
      tick();
    end
    flip_ack();
    wait_busy(0);
    wait_busy(1);
    chk("hold_next_data", bus.src_data, 8'hFF);
    bus.req_valid = '0;
    flip_ack();
    wait_busy(0);
    // spurious ack while idle
    tick(); bus.ack_toggle = ~bus.ack_toggle;
    repeat (6) begin
      neg();
      chk("spur_busy", bus.busy, 0);
      chk("spur_ready", bus.req_ready, 0);
      chk("spur_toggle", bus.src_toggle, 1);
      tick();
    end
    set_req(3, 1, 8'h3C);
    wait_busy(1);
    chk("spur_after_id", bus.src_id, 3);
    chk("spur_after_data", bus.src_data, 8'h3C);
    chk("spur_after_toggle", bus.src_toggle, 0);
    bus.req_valid = '0;
    flip_ack();
    wait_busy(0);
    // reset while a transfer is outstanding
    do_reset();
    set_req(1, 1, 8'h77);
    wait_busy(1);
    chk("mid_toggle_pre", bus.src_toggle, 1);
    set_req(0, 1, 8'h99);
    bus.req_valid = '1;
    @(posedge clk); #3;
    rst_n = 0; bus.ack_toggle = 0;
    #1;
    chk("mid_toggle", bus.src_toggle, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_ready", bus.req_ready, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    neg(); chk("mid_ready_after", bus.req_ready, 4'b0001);
    wait_busy(1);
    chk("mid_id", bus.src_id, 0);
    chk("mid_data", bus.src_data, 8'h99);
    bus.req_valid = '0;
    flip_ack();
    wait_busy(0);
`ifdef DMUX_SYNC_ARB_TIMEOUT_EN
    // timeout with no ack, then a late ack, then ack coinciding with the limit
    do_reset();
    set_req(0, 1, 8'h42);
    wait_busy(1);
    bus.req_valid = '0;
    for (int c = 1; c <= 8; c++) begin
      chk("to_err", bus.timeout_err, c == 8);
      chk("to_busy", bus.busy, 1);
      tick(); neg();
    end
    chk("to_busy_after", bus.busy, 0);
    chk("to_err_after", bus.timeout_err, 0);
    flip_ack();
    repeat (5) begin
      neg(); chk("late_ack_busy", bus.busy, 0); tick();
    end
    set_req(0, 1, 8'h43);
    wait_busy(1);
    bus.req_valid = '0;
    repeat (5) tick();
    bus.ack_toggle = ~bus.ack_toggle;
    neg(); tick(); neg(); tick(); neg();
    chk("tie_err", bus.timeout_err, 0);
    chk("tie_busy", bus.busy, 1);
    tick(); neg();
    chk("tie_busy_after", bus.busy, 0);
`endif
    // randomised traffic with a destination that acks each busy period after a random delay
    do_reset();
    acked = 0; pend = 0;
    for (int n = 0; n < 3000; n++) begin
      neg();
      acc = bus.req_valid & bus.req_ready;
      if (!bus.busy) acked = 0;
      else if (!acked && pend == 0) begin
        acked = 1;
        pend = ($urandom_range(0, 15) == 0) ? 12 : $urandom_range(1, 4);
      end
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) set_req(i, $urandom_range(0, 1) == 1, WIDTH'($urandom));
        else if (bus.req_valid[i]) begin
          if ($urandom_range(0, 9) == 0) bus.req_valid[i] = 0;
        end else set_req(i, $urandom_range(0, 3) == 0, WIDTH'($urandom));
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) bus.ack_toggle = ~bus.ack_toggle;
      end
      if ($urandom_range(0, 299) == 0) bus.ack_toggle = ~bus.ack_toggle;
    end
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
